// File: rtl/cpu_pkg.sv
// Shared CPU constants and types used by fetch and decode.
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111,
    OPC_SYSTEM = 7'b1110011
  } opcode_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries with flush; head reads as zero when empty.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;

  // Pointers and occupancy; flush discards everything including a same-cycle push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Entry storage, no reset needed since the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = (count == CW'(0)) ? '0 : mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: issues in-order word fetches, buffers responses, drops stale ones after redirect.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_LIM = (CW+1)'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] rsp_pc;
  logic [ADDR_W-1:0] redirect_target;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     drop_count;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       occupancy;
  logic              req_fire;
  logic              rsp_keep;
  logic              pop;
  fetch_entry_t      head;
  fetch_entry_t      push_data;

  assign redirect_target = word_align(redirect_pc);

  // Buffered plus in-flight words never exceed DEPTH, so every response has a slot.
  assign occupancy      = {1'b0, fifo_count} + {1'b0, outstanding};
  assign imem_req_valid = ~reset & ~redirect_valid & (occupancy < DEPTH_LIM);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign rsp_keep  = imem_rsp_valid & (drop_count == CW'(0)) & ~redirect_valid;
  assign push_data = '{pc: rsp_pc, instr: imem_rsp_data};

  assign id_valid = (fifo_count != CW'(0)) & ~redirect_valid;
  assign pop      = id_valid & id_ready;
  assign id_instr = head.instr;
  assign id_pc    = head.pc;

  // Request and response address pointers, both retargeted by a redirect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= word_align(RESET_PC);
      rsp_pc   <= word_align(RESET_PC);
    end else if (redirect_valid) begin
      fetch_pc <= redirect_target;
      rsp_pc   <= redirect_target;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
      if (rsp_keep) rsp_pc   <= rsp_pc + PC_STEP;
    end
  end

  // In-flight tracking; on redirect every still-unreturned request becomes stale.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
      drop_count  <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        drop_count <= outstanding - CW'(imem_rsp_valid);
      end else if (imem_rsp_valid && (drop_count != CW'(0))) begin
        drop_count <= drop_count - CW'(1);
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (rsp_keep),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a fixed-latency in-order memory model.
module tb_instr_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // Memory: response appears lsel+1 cycles after the accepting edge's cycle.
  logic [1:0]  lsel = 2'd1;
  logic [3:0]  pv;
  logic [31:0] pa [0:3];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pv <= 4'b0;
      for (int i = 0; i < 4; i++) pa[i] <= 32'h0;
    end else begin
      pv    <= {pv[2:0], imem_req_valid & imem_req_ready};
      pa[0] <= imem_req_addr;
      for (int i = 1; i < 4; i++) pa[i] <= pa[i-1];
    end
  end

  assign imem_rsp_valid = pv[lsel];
  assign imem_rsp_data  = word_of(pa[lsel]);

  int          n_vec = 0;
  int          n_bad = 0;
  int          req_cnt = 0;
  logic [31:0] hs_pc[$];
  logic [31:0] hs_instr[$];

  typedef struct {
    logic        rdy;
    logic        idr;
    logic        exp_rv;
    logic [31:0] exp_addr;
    logic        exp_iv;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic idr, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    reset          = 1'b0;
    imem_req_ready = rdy;
    id_ready       = idr;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    if (imem_req_valid & rdy) req_cnt++;
    if (id_valid & idr) begin
      hs_pc.push_back(id_pc);
      hs_instr.push_back(id_instr);
    end
  endtask

  task automatic do_reset(input logic [1:0] sel);
    @(negedge clk);
    reset          = 1'b1;
    imem_req_ready = 1'b0;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    lsel           = sel;
    #1;
    check_bit("rst_req_valid", imem_req_valid, 1'b0);
    check_bit("rst_id_valid", id_valid, 1'b0);
    check("rst_id_instr", id_instr, 32'h0);
    check("rst_id_pc", id_pc, 32'h0);
    repeat (2) @(negedge clk);
    req_cnt = 0;
    hs_pc.delete();
    hs_instr.delete();
  endtask

  task automatic check_hs(input string name, input int n, input logic [31:0] pcs [5]);
    check({name, "_count"}, hs_pc.size(), n);
    for (int k = 0; k < n; k++) begin
      if (k < hs_pc.size()) begin
        check($sformatf("%s_pc%0d", name, k), hs_pc[k], pcs[k]);
        check($sformatf("%s_instr%0d", name, k), hs_instr[k], word_of(pcs[k]));
      end
    end
  endtask

  initial begin
    logic [31:0] exp_pcs [5];

    tbl[0]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0004, 1'b0, 32'h0000_0000};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0008, 1'b0, 32'h0000_0000};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 32'h0000_000C, 1'b1, 32'h0000_0000};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_0004};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0014, 1'b1, 32'h0000_0008};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0018, 1'b1, 32'h0000_000C};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 32'h0000_001C, 1'b1, 32'h0000_0010};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 32'h0000_001C, 1'b1, 32'h0000_0014};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 32'h0000_001C, 1'b1, 32'h0000_0018};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 32'h0000_0020, 1'b0, 32'h0000_0000};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 32'h0000_0024, 1'b0, 32'h0000_0000};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 32'h0000_0028, 1'b1, 32'h0000_001C};

    // Streaming with 2-cycle latency, then a two-cycle request stall.
    do_reset(2'd1);
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].rdy, tbl[i].idr, 1'b0, 32'h0);
      check_bit($sformatf("v%0d_req_valid", i), imem_req_valid, tbl[i].exp_rv);
      check($sformatf("v%0d_req_addr", i), imem_req_addr, tbl[i].exp_addr);
      check_bit($sformatf("v%0d_id_valid", i), id_valid, tbl[i].exp_iv);
      if (tbl[i].exp_iv) begin
        check($sformatf("v%0d_id_pc", i), id_pc, tbl[i].exp_pc);
        check($sformatf("v%0d_id_instr", i), id_instr, word_of(tbl[i].exp_pc));
      end
    end

    // Decode stalled: exactly DEPTH requests, FIFO fills, requests stop.
    do_reset(2'd1);
    repeat (20) drive(1'b1, 1'b0, 1'b0, 32'h0);
    check("full_req_cnt", req_cnt, 32'd4);
    check_bit("full_req_valid", imem_req_valid, 1'b0);
    check("full_fifo_count", 32'(dut.fifo_count), 32'd4);
    check("full_head_pc", id_pc, 32'h0);
    for (int i = 0; i < 30 && hs_pc.size() < 5; i++) drive(1'b1, 1'b1, 1'b0, 32'h0);
    exp_pcs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    check_hs("drain", 5, exp_pcs);

    // Redirect with three requests in flight (3-cycle latency).
    do_reset(2'd2);
    repeat (3) drive(1'b1, 1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0043);
    check("rd3_outstanding", 32'(dut.outstanding), 32'd3);
    check_bit("rd3_req_valid", imem_req_valid, 1'b0);
    check_bit("rd3_id_valid", id_valid, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    check_bit("rd3_next_req_valid", imem_req_valid, 1'b1);
    check("rd3_next_addr", imem_req_addr, 32'h40);
    for (int i = 0; i < 40 && hs_pc.size() < 3; i++) drive(1'b1, 1'b1, 1'b0, 32'h0);
    exp_pcs = '{32'h40, 32'h44, 32'h48, 32'h0, 32'h0};
    check_hs("rd3", 3, exp_pcs);

    // Redirect coincident with id_ready on a full FIFO: no handshake, FIFO flushed.
    do_reset(2'd1);
    repeat (10) drive(1'b1, 1'b0, 1'b0, 32'h0);
    check("rdh_fifo_before", 32'(dut.fifo_count), 32'd4);
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0040);
    check_bit("rdh_id_valid", id_valid, 1'b0);
    check_bit("rdh_req_valid", imem_req_valid, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    check("rdh_hs_none", hs_pc.size(), 32'd0);
    check_bit("rdh_id_valid_after", id_valid, 1'b0);
    check("rdh_fifo_after", 32'(dut.fifo_count), 32'd0);
    check_bit("rdh_req_valid_after", imem_req_valid, 1'b1);
    check("rdh_addr_after", imem_req_addr, 32'h40);
    for (int i = 0; i < 20 && hs_pc.size() < 1; i++) drive(1'b1, 1'b1, 1'b0, 32'h0);
    exp_pcs = '{32'h40, 32'h0, 32'h0, 32'h0, 32'h0};
    check_hs("rdh", 1, exp_pcs);

    // Address wrap at the top of the address space, with stale words in flight.
    drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);
    hs_pc.delete();
    hs_instr.delete();
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    check("wrap_addr0", imem_req_addr, 32'hFFFF_FFFC);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    check_bit("wrap_req_valid1", imem_req_valid, 1'b1);
    check("wrap_addr1", imem_req_addr, 32'h0000_0000);
    for (int i = 0; i < 20 && hs_pc.size() < 2; i++) drive(1'b1, 1'b1, 1'b0, 32'h0);
    exp_pcs = '{32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0, 32'h0};
    check_hs("wrap", 2, exp_pcs);

    // Reset with two requests in flight, then a clean restart.
    do_reset(2'd1);
    repeat (5) drive(1'b1, 1'b1, 1'b0, 32'h0);
    check("mid_outstanding", 32'(dut.outstanding), 32'd2);
    do_reset(2'd1);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    check_bit("rr_req_valid", imem_req_valid, 1'b1);
    check("rr_addr", imem_req_addr, 32'h0);
    check_bit("rr_id_valid0", id_valid, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    check_bit("rr_id_valid1", id_valid, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    check_bit("rr_id_valid2", id_valid, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    check_bit("rr_id_valid3", id_valid, 1'b1);
    check("rr_id_pc3", id_pc, 32'h0);
    check("rr_id_instr3", id_instr, word_of(32'h0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4: prefetch FIFO entries; power of two, 2..16.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port imem_req_valid, output, 1: fetch request valid.
REQ-006 SHALL have port imem_req_ready, input, 1: memory accepts request.
REQ-007 SHALL have port imem_req_addr, output, 32: word-aligned fetch address; bits [1:0] always 0.
REQ-008 SHALL have port imem_rsp_valid, input, 1: instruction word returned, in request order, latency >=1 cycle.
REQ-009 SHALL have port imem_rsp_data, input, 32: returned instruction.
REQ-010 SHALL have port id_valid, output, 1: instruction available to decode.
REQ-011 SHALL have port id_ready, input, 1: decode consumes instruction.
REQ-012 SHALL have port id_instr, output, 32: instruction at FIFO head.
REQ-013 SHALL have port id_pc, output, 32: address of id_instr.
REQ-014 SHALL have port redirect_valid, input, 1: branch/jump taken; flush and refetch.
REQ-015 SHALL have port redirect_pc, input, 32: new fetch target; bits [1:0] ignored.

Function
REQ-016 SHALL hold fetch_pc; request accepted (imem_req_valid & imem_req_ready) advances fetch_pc by 4, wrapping mod 2^32.
REQ-017 SHALL assert imem_req_valid only when fifo_count + outstanding < DEPTH and not in redirect cycle; response space always guaranteed.
REQ-018 SHALL track outstanding (accepted, unreturned requests), width clog2(DEPTH)+1; accept and response in same cycle leave it unchanged.
REQ-019 SHALL push {pc, data} into FIFO on imem_rsp_valid unless drop_count > 0; pc is request address, tracked by a second pointer advancing per kept response.
REQ-020 SHALL drive id_valid = (fifo_count != 0) & ~redirect_valid; handshake pops head.
REQ-021 SHALL allow simultaneous push and pop when FIFO full or empty-with-bypass disabled: no combinational rsp->id path; minimum rsp-to-id_valid latency 1 cycle.
REQ-022 SHALL on redirect_valid: clear FIFO (count 0), set fetch_pc and response pc pointer to {redirect_pc[31:2],2'b00}, set drop_count = outstanding minus any response arriving that cycle, deassert imem_req_valid that cycle.
REQ-023 SHALL discard responses while drop_count > 0, decrementing per response; fetch resumes the cycle after redirect.
REQ-024 SHALL treat redirect in same cycle as id_ready: no handshake occurs (id_valid low); redirect wins over push, pop and request.
REQ-025 SHALL hold imem_req_addr stable while imem_req_valid & ~imem_req_ready, unless redirect.
REQ-026 SHALL never overflow FIFO nor underflow outstanding; assertion-checkable.

Reset
REQ-027 SHALL on reset: fetch_pc = RESET_PC, response pc = RESET_PC, fifo_count = 0, outstanding = 0, drop_count = 0; imem_req_valid = 0, id_valid = 0, id_instr = 0, id_pc = 0.
REQ-028 SHALL issue first request in cycle after reset deasserts.
REQ-029 SHALL on reset mid-operation abandon all in-flight requests; responses arriving during reset are ignored, and memory is reset alongside.

Structure
REQ-030 SHALL place INSTR_W=32, ADDR_W=32, PC_STEP=4 and the opcode constants shared with decode in package cpu_pkg.
REQ-031 SHALL use one sub-module, fetch_fifo (DEPTH x 64-bit, flush input, count output).

Verification
REQ-032 SHALL cover reset, imem_req_ready=1, 2-cycle latency, id_ready=1 -> id_pc sequence 0,4,8,12 with matching words, first id_valid cycle 3.
REQ-033 SHALL cover id_ready=0 for 20 cycles -> exactly 4 requests issued, FIFO full, imem_req_valid low; release -> in-order 0..12 then 16.
REQ-034 SHALL cover redirect_pc=0x40 with 3 outstanding -> 3 responses dropped, next id_pc=0x40, no stale word seen.
REQ-035 SHALL cover redirect_valid and id_ready high same cycle with FIFO non-empty -> no handshake, FIFO empty next cycle, request addr 0x40.
REQ-036 SHALL cover fetch_pc=0xFFFF_FFFC -> next request addr 0x0000_0000.
REQ-037 SHALL cover reset asserted with 2 outstanding, released -> first request addr RESET_PC, id_valid low until new response.
